// File: rtl/memwb_if.sv
// Bundles the execute-to-memwb submit bus and the data-memory request bus.
// Latency: none (wires only).
// Backpressure: o_ready toward execute, req held until i_mem_ack toward memory.
//
// master : execute stage plus memory model (drives every i_* signal)
// slave  : the memwb stage (drives every o_* signal)
interface memwb_if #(
   parameter int RW    = 16,
   parameter int REGNO = 8
);
   // execute -> memwb
   logic             i_submit;
   logic             o_ready;
   logic [RW-1:0]    i_data;
   logic [RW-1:0]    i_addr;
   logic [REGNO-1:0] i_reg_ie;
   logic             i_mem_access;
   logic             i_mem_we;
   logic             i_mem_width;
   // memwb <-> data memory
   logic             o_mem_req;
   logic             o_mem_we;
   logic [RW-1:0]    o_mem_addr;
   logic [RW-1:0]    o_mem_data;
   logic [1:0]       o_mem_sel;
   logic             i_mem_ack;
   logic [RW-1:0]    i_mem_data;
   // memwb -> register file
   logic [REGNO-1:0] o_reg_ie;
   logic [RW-1:0]    o_reg_data;

   modport master (
      output i_submit, i_data, i_addr, i_reg_ie, i_mem_access, i_mem_we,
             i_mem_width, i_mem_ack, i_mem_data,
      input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_data,
             o_mem_sel, o_reg_ie, o_reg_data
   );

   modport slave (
      input  i_submit, i_data, i_addr, i_reg_ie, i_mem_access, i_mem_we,
             i_mem_width, i_mem_ack, i_mem_data,
      output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_data,
             o_mem_sel, o_reg_ie, o_reg_data
   );
endinterface

// File: rtl/memwb.sv
// Memory/writeback stage: ALU results write back directly, loads/stores go over a req/ack bus.
// Latency: ALU op 0 cycles; memory op writes back in the ack cycle (earliest one cycle after submit).
// Backpressure: o_ready low for every MEM cycle; req and its fields held stable until i_mem_ack.
//
// Ports: i_clk, i_rst_n (async, active-low) plus a memwb_if.slave carrying
// the submit bus from execute, the memory request bus and the register-file write port.
module memwb #(
   parameter int RW    = 16,
   parameter int REGNO = 8
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   memwb_if.slave bus
);

   typedef enum logic {IDLE, MEM} state_t;

   state_t           state_q;
   logic             req_q;
   logic             we_q;
   logic             width_q;
   logic [1:0]       sel_q;
   logic [RW-1:0]    addr_q;
   logic [RW-1:0]    mdata_q;
   logic [REGNO-1:0] reg_ie_q;

   logic             in_mem;
   logic             wb_alu;
   logic             wb_mem;
   logic [RW-1:0]    load_data;

   assign in_mem = (state_q == MEM);

   // Request outputs are registered so they stay stable for the whole wait.
   // Leaving MEM clears them, so the bus reads all-zero whenever idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         width_q  <= 1'b0;
         sel_q    <= 2'b00;
         addr_q   <= '0;
         mdata_q  <= '0;
         reg_ie_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.i_submit && bus.i_mem_access) begin
                  state_q  <= MEM;
                  req_q    <= 1'b1;
                  we_q     <= bus.i_mem_we;
                  width_q  <= bus.i_mem_width;
                  sel_q    <= bus.i_mem_width ? 2'b01 : 2'b11;
                  addr_q   <= bus.i_addr;
                  // byte stores drive only the low lane; upper lane forced to zero
                  mdata_q  <= bus.i_mem_width ? {{(RW-8){1'b0}}, bus.i_data[7:0]}
                                              : bus.i_data;
                  reg_ie_q <= bus.i_reg_ie;
               end
            end
            MEM: begin
               // submits arriving here are ignored: o_ready is low
               if (bus.i_mem_ack) begin
                  state_q  <= IDLE;
                  req_q    <= 1'b0;
                  we_q     <= 1'b0;
                  width_q  <= 1'b0;
                  sel_q    <= 2'b00;
                  addr_q   <= '0;
                  mdata_q  <= '0;
                  reg_ie_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Byte loads zero-extend the low lane.
   assign load_data = width_q ? {{(RW-8){1'b0}}, bus.i_mem_data[7:0]} : bus.i_mem_data;

   // Reset gating keeps the register file quiet while reset is held,
   // even if execute is still presenting a submit.
   assign wb_alu = i_rst_n && !in_mem && bus.i_submit && !bus.i_mem_access;
   assign wb_mem = i_rst_n && in_mem && bus.i_mem_ack && !we_q;

   always_comb begin
      bus.o_reg_ie   = '0;
      bus.o_reg_data = '0;
      if (wb_alu) begin
         bus.o_reg_ie   = bus.i_reg_ie;
         bus.o_reg_data = bus.i_data;
      end else if (wb_mem) begin
         bus.o_reg_ie   = reg_ie_q;
         bus.o_reg_data = load_data;
      end
   end

   assign bus.o_ready    = !in_mem;
   assign bus.o_mem_req  = req_q;
   assign bus.o_mem_we   = we_q;
   assign bus.o_mem_addr = addr_q;
   assign bus.o_mem_data = mdata_q;
   assign bus.o_mem_sel  = sel_q;

endmodule

// File: tb/tb_memwb.sv
// Self-checking bench for memwb: vector table for single-cycle behaviour,
// hand sequences for memory transactions, scoreboard for every writeback.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_memwb;

   logic clk;
   logic rst_n;

   memwb_if #(.RW(16), .REGNO(8)) bus ();

   memwb #(.RW(16), .REGNO(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  ie;
      logic [15:0] data;
   } wb_t;

   wb_t sb[$];

   int n_pass;
   int n_total;

   typedef struct {
      string       name;
      logic        submit;
      logic        mem_ack;
      logic [7:0]  reg_ie;
      logic [15:0] data;
      logic [15:0] mem_rdata;
      logic [7:0]  exp_ie;
      logic [15:0] exp_data;
      logic        exp_ready;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Every nonzero writeback must match the oldest expected entry.
   task automatic sb_monitor();
      wb_t got;
      if (bus.o_reg_ie !== 8'h00) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: got writeback ie=%h data=%h, expected none",
                     bus.o_reg_ie, bus.o_reg_data);
         end else begin
            got = sb.pop_front();
            chk("sb_ie", {24'h0, bus.o_reg_ie}, {24'h0, got.ie});
            chk("sb_data", {16'h0, bus.o_reg_data}, {16'h0, got.data});
         end
      end
   endtask

   task automatic settle();
      @(negedge clk);
      sb_monitor();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_submit     = 1'b0;
      bus.i_data       = 16'h0000;
      bus.i_addr       = 16'h0000;
      bus.i_reg_ie     = 8'h00;
      bus.i_mem_access = 1'b0;
      bus.i_mem_we     = 1'b0;
      bus.i_mem_width  = 1'b0;
      bus.i_mem_ack    = 1'b0;
      bus.i_mem_data   = 16'h0000;
   endtask

   task automatic drive_mem(input logic [15:0] addr, input logic [15:0] data,
                            input logic [7:0] ie, input logic we, input logic width);
      bus.i_submit     = 1'b1;
      bus.i_mem_access = 1'b1;
      bus.i_addr       = addr;
      bus.i_data       = data;
      bus.i_reg_ie     = ie;
      bus.i_mem_we     = we;
      bus.i_mem_width  = width;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;

      vecs[0] = '{"alu_a",      1'b1, 1'b0, 8'h04, 16'h1234, 16'h0000, 8'h04, 16'h1234, 1'b1};
      vecs[1] = '{"alu_b",      1'b1, 1'b0, 8'h01, 16'hBEEF, 16'h0000, 8'h01, 16'hBEEF, 1'b1};
      vecs[2] = '{"spur_ack",   1'b0, 1'b1, 8'h10, 16'h5555, 16'h9999, 8'h00, 16'h0000, 1'b1};
      vecs[3] = '{"alu_c",      1'b1, 1'b1, 8'h80, 16'h0001, 16'h7777, 8'h80, 16'h0001, 1'b1};
      vecs[4] = '{"no_submit",  1'b0, 1'b0, 8'h20, 16'hAAAA, 16'h0000, 8'h00, 16'h0000, 1'b1};

      // ---------------- reset state
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      settle();
      chk("rst_ready",    {31'h0, bus.o_ready},     32'h1);
      chk("rst_req",      {31'h0, bus.o_mem_req},   32'h0);
      chk("rst_we",       {31'h0, bus.o_mem_we},    32'h0);
      chk("rst_addr",     {16'h0, bus.o_mem_addr},  32'h0);
      chk("rst_mdata",    {16'h0, bus.o_mem_data},  32'h0);
      chk("rst_sel",      {30'h0, bus.o_mem_sel},   32'h0);
      chk("rst_reg_ie",   {24'h0, bus.o_reg_ie},    32'h0);
      chk("rst_reg_data", {16'h0, bus.o_reg_data},  32'h0);
      adv();
      rst_n = 1'b1;
      adv();

      // ---------------- table: ALU back-to-back and spurious ack in IDLE
      for (int i = 0; i < 5; i++) begin
         bus.i_submit     = vecs[i].submit;
         bus.i_mem_access = 1'b0;
         bus.i_mem_ack    = vecs[i].mem_ack;
         bus.i_reg_ie     = vecs[i].reg_ie;
         bus.i_data       = vecs[i].data;
         bus.i_mem_data   = vecs[i].mem_rdata;
         if (vecs[i].exp_ie != 8'h00) sb.push_back({vecs[i].exp_ie, vecs[i].exp_data});
         settle();
         chk({vecs[i].name, "_ie"},    {24'h0, bus.o_reg_ie},   {24'h0, vecs[i].exp_ie});
         chk({vecs[i].name, "_data"},  {16'h0, bus.o_reg_data}, {16'h0, vecs[i].exp_data});
         chk({vecs[i].name, "_ready"}, {31'h0, bus.o_ready},    {31'h0, vecs[i].exp_ready});
         chk({vecs[i].name, "_req"},   {31'h0, bus.o_mem_req},  32'h0);
         adv();
      end
      idle_inputs();

      // ---------------- word load, 3 wait states
      drive_mem(16'h0040, 16'h0000, 8'h02, 1'b0, 1'b0);
      settle();
      chk("wl_sub_ie",    {24'h0, bus.o_reg_ie},  32'h0);
      chk("wl_sub_req",   {31'h0, bus.o_mem_req}, 32'h0);
      chk("wl_sub_ready", {31'h0, bus.o_ready},   32'h1);
      adv();
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            bus.i_mem_ack  = 1'b1;
            bus.i_mem_data = 16'hA5C3;
            sb.push_back({8'h02, 16'hA5C3});
         end
         settle();
         chk("wl_req",   {31'h0, bus.o_mem_req},  32'h1);
         chk("wl_addr",  {16'h0, bus.o_mem_addr}, 32'h0040);
         chk("wl_sel",   {30'h0, bus.o_mem_sel},  32'h3);
         chk("wl_we",    {31'h0, bus.o_mem_we},   32'h0);
         chk("wl_ready", {31'h0, bus.o_ready},    32'h0);
         if (k == 3) chk("wl_wb_ie", {24'h0, bus.o_reg_ie}, 32'h02);
         else        chk("wl_wait_ie", {24'h0, bus.o_reg_ie}, 32'h0);
         adv();
      end
      idle_inputs();
      settle();
      chk("wl_after_ready", {31'h0, bus.o_ready},   32'h1);
      chk("wl_after_req",   {31'h0, bus.o_mem_req}, 32'h0);
      adv();

      // ---------------- byte load, ack in first request cycle
      drive_mem(16'h0041, 16'h0000, 8'h10, 1'b0, 1'b1);
      settle();
      adv();
      idle_inputs();
      bus.i_mem_ack  = 1'b1;
      bus.i_mem_data = 16'hFF7E;
      sb.push_back({8'h10, 16'h007E});
      settle();
      chk("bl_sel",  {30'h0, bus.o_mem_sel},  32'h1);
      chk("bl_data", {16'h0, bus.o_reg_data}, 32'h007E);
      adv();
      idle_inputs();
      settle();
      chk("bl_after_ready", {31'h0, bus.o_ready}, 32'h1);
      adv();

      // ---------------- byte store, one wait state
      drive_mem(16'h0100, 16'h12AB, 8'h08, 1'b1, 1'b1);
      settle();
      adv();
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
         if (k == 1) begin
            bus.i_mem_ack  = 1'b1;
            bus.i_mem_data = 16'hFFFF;
         end
         settle();
         chk("bs_we",    {31'h0, bus.o_mem_we},   32'h1);
         chk("bs_mdata", {16'h0, bus.o_mem_data}, 32'h00AB);
         chk("bs_sel",   {30'h0, bus.o_mem_sel},  32'h1);
         chk("bs_addr",  {16'h0, bus.o_mem_addr}, 32'h0100);
         chk("bs_ie",    {24'h0, bus.o_reg_ie},   32'h0);
         adv();
      end
      idle_inputs();
      settle();
      chk("bs_after_ready", {31'h0, bus.o_ready},  32'h1);
      chk("bs_after_we",    {31'h0, bus.o_mem_we}, 32'h0);
      adv();

      // ---------------- submits during MEM are ignored
      drive_mem(16'h0200, 16'h0000, 8'h20, 1'b0, 1'b0);
      settle();
      adv();
      idle_inputs();
      bus.i_submit = 1'b1;
      bus.i_reg_ie = 8'h40;
      bus.i_data   = 16'h7777;
      settle();
      chk("ign_alu_ie",    {24'h0, bus.o_reg_ie}, 32'h0);
      chk("ign_alu_ready", {31'h0, bus.o_ready},  32'h0);
      adv();
      drive_mem(16'h0300, 16'h5A5A, 8'h04, 1'b1, 1'b1);
      settle();
      adv();
      idle_inputs();
      bus.i_mem_ack  = 1'b1;
      bus.i_mem_data = 16'h0099;
      sb.push_back({8'h20, 16'h0099});
      settle();
      chk("ign_addr", {16'h0, bus.o_mem_addr}, 32'h0200);
      chk("ign_we",   {31'h0, bus.o_mem_we},   32'h0);
      chk("ign_sel",  {30'h0, bus.o_mem_sel},  32'h3);
      adv();
      idle_inputs();
      settle();
      chk("ign_after_ready", {31'h0, bus.o_ready}, 32'h1);
      adv();

      // ---------------- reset mid-MEM
      drive_mem(16'h0400, 16'h0000, 8'h01, 1'b0, 1'b0);
      settle();
      adv();
      idle_inputs();
      settle();
      chk("rm_req_before", {31'h0, bus.o_mem_req}, 32'h1);
      adv();
      rst_n          = 1'b0;
      bus.i_mem_ack  = 1'b1;
      bus.i_mem_data = 16'h1111;
      #1;
      sb_monitor();
      chk("rm_req",   {31'h0, bus.o_mem_req},  32'h0);
      chk("rm_ready", {31'h0, bus.o_ready},    32'h1);
      chk("rm_ie",    {24'h0, bus.o_reg_ie},   32'h0);
      chk("rm_addr",  {16'h0, bus.o_mem_addr}, 32'h0);
      settle();
      adv();
      adv();
      idle_inputs();
      rst_n = 1'b1;
      adv();
      bus.i_submit = 1'b1;
      bus.i_reg_ie = 8'h02;
      bus.i_data   = 16'hCAFE;
      sb.push_back({8'h02, 16'hCAFE});
      settle();
      chk("rm_alu_ie",   {24'h0, bus.o_reg_ie},   32'h02);
      chk("rm_alu_data", {16'h0, bus.o_reg_data}, 32'hCAFE);
      adv();
      idle_inputs();
      settle();

      chk("sb_drained", sb.size(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/memwb.md
# memwb

Final pipeline stage of the core, directly downstream of the execute stage. It takes each submitted instruction's result, address and memory-control bits. It performs the data-memory access over a request/acknowledge bus when one is required. It then produces the register-file write enable and data, which execute feeds straight into its register file.

## Interface
Parameters:
- RW, 16: data/address width (`RW).
- REGNO, 8: number of architectural registers (`REGNO); width of the write-enable one-hot.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_submit  in  1  execute presents a valid instruction this cycle.
- o_ready  out  1  stage can accept a submit this cycle.
- i_data  in  RW  ALU/sreg result, or store data for memory ops.
- i_addr  in  RW  memory word address.
- i_reg_ie  in  REGNO  one-hot destination register enable; all-zero means no writeback.
- i_mem_access  in  1  instruction accesses memory.
- i_mem_we  in  1  access is a store (valid with i_mem_access).
- i_mem_width  in  1  0 = 16-bit access, 1 = 8-bit access (low byte lane).
- o_mem_req  out  1  memory request, held until acknowledged.
- o_mem_we  out  1  request is a write.
- o_mem_addr  out  RW  request word address.
- o_mem_data  out  RW  write data.
- o_mem_sel  out  2  byte-lane select: 2'b11 word, 2'b01 low byte.
- i_mem_ack  in  1  memory completes the request this cycle; i_mem_data valid for reads.
- i_mem_data  in  RW  read data.
- o_reg_ie  out  REGNO  register-file write enable, one-cycle pulse per writeback.
- o_reg_data  out  RW  register-file write data.

## Operation
- States: IDLE, MEM.
- o_ready = (state == IDLE). A submit while o_ready=0 is a protocol violation and is ignored.
- IDLE with i_submit and ~i_mem_access:
  - combinational writeback in the same cycle: o_reg_ie = i_reg_ie, o_reg_data = i_data.
  - state stays IDLE.
- IDLE with i_submit and i_mem_access:
  - latch addr, data, we, width and reg_ie; go to MEM.
  - o_mem_req = 1 from the next cycle.
  - no writeback in the submit cycle.
- MEM, request outputs:
  - o_mem_req = 1. o_mem_addr, o_mem_we and o_mem_sel come from the latched values.
  - o_mem_sel = width ? 2'b01 : 2'b11.
  - o_mem_data = width ? {8'h00, data[7:0]} : data.
  - All request outputs are held stable until ack.
- MEM, i_mem_ack=1:
  - Load: writeback in the same cycle with o_reg_ie = latched reg_ie. o_reg_data = width ? {8'h00, i_mem_data[7:0]} (zero-extend) : i_mem_data.
  - Store: o_reg_ie = 0 regardless of latched reg_ie.
  - Next state IDLE; o_mem_req drops next cycle.
- MEM, i_mem_ack=0: remain in MEM and hold all outputs.
- Outside a writeback cycle: o_reg_ie = 0, o_reg_data = 0.
- i_mem_ack while not in MEM is ignored.
- The stage has no flush input. An instruction submitted by execute is committed and always completes.

## Timing
- Reset (async assert): state = IDLE and o_mem_req = 0. o_mem_we = 0, o_mem_addr = 0, o_mem_data = 0, o_mem_sel = 0 (all request outputs are zero when not in MEM). Latched fields are cleared. o_reg_ie = 0, o_reg_data = 0, o_ready = 1. Deassertion takes effect on the next rising edge.
- Reset mid-transaction aborts it: the request drops immediately and no writeback occurs.
- ALU op latency: 0 cycles (writeback in the submit cycle); throughput one per cycle.
- Memory op:
  - req is asserted in cycle N+1 after a submit in cycle N.
  - The earliest ack is cycle N+1, giving the writeback in N+1 and o_ready=1 again in N+2.
  - Each wait cycle adds one cycle.
- o_ready falls in N+1 and is low for every MEM cycle.

## Test plan
- Reset: with i_rst_n=0 mid-MEM, o_mem_req drops at once, o_ready=1, o_reg_ie=0; after release, ALU submit works.
- ALU back-to-back: submit reg_ie=8'h04 with data 16'h1234, then reg_ie=8'h01 with data 16'hBEEF on consecutive cycles -> o_reg_ie/o_reg_data match the submit in each same cycle; o_ready stays 1.
- Word load, 3 wait states: addr 16'h0040, reg_ie=8'h02, mem returns 16'hA5C3 on the 4th req cycle -> req/addr/sel=11 stable for 4 cycles; writeback 8'h02/16'hA5C3 in the ack cycle; o_ready=1 the next cycle.
- Byte load: width=1, mem returns 16'hFF7E with ack in the first req cycle -> o_mem_sel=01, o_reg_data=16'h007E.
- Byte store: data 16'h12AB, width=1, reg_ie=8'h08 -> o_mem_we=1, o_mem_data=16'h00AB, sel=01; o_reg_ie remains 0 through the ack.
- Submit ignored: a second i_submit during MEM is ignored (no latch change, no writeback); a spurious i_mem_ack in IDLE has no effect.
